mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one physical memory port between the instruction-fetch requester (read-only) and the
//   data requester (load/store) of the multicycle rv32i CPU, or any two such masters.
// - Sits between cpu_control/datapath memory signals and the memory model/cache; one transaction
//   in flight at a time; round-robin on conflict; address/data/mask latched at grant.
// PARAMETERS
// - ADDR_W  32  address width (bits)
// - DATA_W  32  data width (bits); byte-enable width = DATA_W/8
// PORTS
// - clk              in   1         system clock; all state updates on posedge
// - rst              in   1         reset, synchronous, active-high
// - i_read           in   1         inst requester read request (level, held until i_resp)
// - i_address        in   ADDR_W    inst read address
// - i_rdata          out  DATA_W    inst read data, valid when i_resp=1
// - i_resp           out  1         inst transaction complete (1-cycle pulse)
// - d_read           in   1         data read request (level, held until d_resp)
// - d_write          in   1         data write request (level, held until d_resp)
// - d_address        in   ADDR_W    data address
// - d_wdata          in   DATA_W    data write data
// - d_byte_enable    in   DATA_W/8  write byte mask
// - d_rdata          out  DATA_W    data read data, valid when d_resp=1
// - d_resp           out  1         data transaction complete (1-cycle pulse)
// - mem_read         out  1         downstream read strobe
// - mem_write        out  1         downstream write strobe
// - mem_address      out  ADDR_W    downstream address (registered)
// - mem_wdata        out  DATA_W    downstream write data (registered)
// - mem_byte_enable  out  DATA_W/8  downstream mask (registered; 4'b1111-equivalent on reads)
// - mem_rdata        in   DATA_W    downstream read data, valid with mem_resp
// - mem_resp         in   1         downstream completion
// BEHAVIOUR
// - States: IDLE, I_BUSY, D_BUSY. Reset -> IDLE; last_grant <= INST (so first conflict goes to data).
// - Reset values: mem_read=mem_write=0, mem_address=mem_wdata=0, mem_byte_enable=all-ones,
//   i_resp=d_resp=0; i_rdata/d_rdata = mem_rdata (pass-through, don't-care when resp=0).
// - IDLE: pending_i=i_read, pending_d=d_read|d_write. None -> stay. One -> grant it. Both -> grant
//   the one not equal to last_grant. On grant (registered): latch address/wdata/mask, set last_grant,
//   go I_BUSY/D_BUSY. Strobes assert the cycle after the request is first seen (1-cycle arb latency).
// - I_BUSY: mem_read=1, mask all-ones. D_BUSY: mem_write=1 if latched write else mem_read=1.
//   d_write and d_read both high at grant -> write wins.
// - Completion: in X_BUSY with mem_resp=1 -> X_resp=1 combinationally that cycle, mem_rdata routed;
//   next state IDLE. mem_resp never routed to the non-granted side.
// - IDLE inserted between back-to-back transactions (min 1 idle cycle); requester must drop its
//   request the cycle after resp, else it re-arbitrates as a new request.
// - mem_resp in IDLE: ignored. Request changes while busy: ignored (latched values used).
// - Requester dropping its request while granted: transaction still completes; resp still pulses.
// - rst mid-transaction: strobes drop next edge, state IDLE, in-flight access abandoned, no resp.
// - Strobes and mem_address/mem_wdata/mem_byte_enable are stable for the whole busy period.
// STRUCTURE
// - Package rv32i_types gains arb_state_t (IDLE/I_BUSY/D_BUSY) and arb_grant_t (INST/DATA);
//   reuses rv32i_word and rv32i_mem_wmask for the DATA_W=32 build.
// - One natural sub-module: mem_arb_pick (combinational round-robin picker: pending_i, pending_d,
//   last_grant -> grant_valid, grant_sel). FSM, latches and response routing stay in the top.
// TESTING
// - Lone fetch: i_read=1,i_address=0x60 at cyc0 -> mem_read=1,mem_address=0x60 from cyc1; memory
//   resp at cyc3 with 0x00000013 -> i_resp=1,i_rdata=0x13 at cyc3; mem_read=0 at cyc4.
// - Lone store: d_write=1,addr=0x100,wdata=0xDEADBEEF,mask=4'b0011 -> mem_write=1 with those exact
//   values held until mem_resp; d_resp one cycle; i_resp stays 0.
// - Conflict fairness: i_read and d_read held continuously from reset -> grants D,I,D,I...;
//   each side gets exactly one resp per two transactions, no starvation over 20 transactions.
// - Stray/ignored inputs: mem_resp pulsed in IDLE -> no i_resp/d_resp; d_address changed mid-D_BUSY
//   -> mem_address unchanged.
// - Reset mid-op: rst=1 during I_BUSY before mem_resp -> next cycle mem_read=0, no i_resp, state IDLE;
//   after rst release a held i_read is re-granted with 1-cycle latency.
// - Read+write both high: d_read=d_write=1 -> mem_write=1, mem_read=0 for the whole transaction.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared rv32i types plus the state and grant encodings used by the memory port arbiter.
package rv32i_types;

  localparam int unsigned RV32I_XLEN   = 32;
  localparam int unsigned RV32I_MASK_W = RV32I_XLEN / 8;

  typedef logic [RV32I_XLEN-1:0]   rv32i_word;
  typedef logic [RV32I_MASK_W-1:0] rv32i_mem_wmask;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } arb_grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational round-robin picker: a lone requester wins outright.
// On conflict, the side that did not win last time wins.
module mem_arb_pick
  import rv32i_types::*;
(
  input  logic       pend_inst_i,
  input  logic       pend_data_i,
  input  arb_grant_t last_grant_i,
  output logic       grant_valid_c_o,
  output arb_grant_t grant_sel_c_o
);

  always_comb begin
    grant_valid_c_o = pend_inst_i | pend_data_i;
    grant_sel_c_o   = INST;
    if (pend_inst_i && pend_data_i) begin
      grant_sel_c_o = (last_grant_i == INST) ? DATA : INST;
    end else if (pend_data_i) begin
      grant_sel_c_o = DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction-fetch master and a load/store master.
// Only one transaction is in flight at a time; address, data and mask are latched at grant.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_address,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_resp,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byte_enable,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  arb_grant_t        last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              wr_q, wr_d;

  logic       grant_valid;
  arb_grant_t grant_sel;

  mem_arb_pick u_pick (
    .pend_inst_i     (i_read),
    .pend_data_i     (d_read | d_write),
    .last_grant_i    (last_q),
    .grant_valid_c_o (grant_valid),
    .grant_sel_c_o   (grant_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= INST;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '1;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
    end
  end

  // Next state, grant latching and completion routing.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_d = grant_sel;
          if (grant_sel == INST) begin
            addr_d  = i_address;
            be_d    = '1;
            wr_d    = 1'b0;
            state_d = I_BUSY;
          end else begin
            addr_d  = d_address;
            wdata_d = d_wdata;
            wr_d    = d_write;
            be_d    = d_write ? d_byte_enable : '1;
            state_d = D_BUSY;
          end
        end
      end
      I_BUSY: begin
        if (mem_resp) begin
          i_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      D_BUSY: begin
        if (mem_resp) begin
          d_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode directly from registered state so they hold for the whole busy period.
  assign mem_read        = (state_q == I_BUSY) || ((state_q == D_BUSY) && !wr_q);
  assign mem_write       = (state_q == D_BUSY) && wr_q;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = be_q;
  assign i_rdata         = mem_rdata;
  assign d_rdata         = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected responses go into a queue when
// a transaction is launched, and a negedge monitor pops them as responses appear.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_byte_enable;
  logic [DATA_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_byte_enable;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  typedef struct packed {
    logic        side;      // 0 = inst, 1 = data
    logic        has_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_i_resp = 0;
  int   n_d_resp = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_read          (i_read),
    .i_address       (i_address),
    .i_rdata         (i_rdata),
    .i_resp          (i_resp),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_address       (d_address),
    .d_wdata         (d_wdata),
    .d_byte_enable   (d_byte_enable),
    .d_rdata         (d_rdata),
    .d_resp          (d_resp),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic side, input logic has_data, input logic [31:0] data);
    exp_t e;
    e.side = side;
    e.has_data = has_data;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: every response must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (i_resp || d_resp) begin
      if (i_resp && d_resp) chk("dual_resp", 32'(i_resp & d_resp), 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", {30'd0, i_resp, d_resp}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_side", 32'(d_resp), 32'(e.side));
        if (e.has_data) chk("resp_data", d_resp ? d_rdata : i_rdata, e.data);
        if (d_resp) n_d_resp++;
        else n_i_resp++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  i0, d0;
    bit  seen;
    logic exp_side;
    rst = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0; d_byte_enable = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_byte_enable), 32'hF);
    chk("rst_resp", {30'd0, i_resp, d_resp}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Lone fetch: strobe one cycle after the request, response at cyc3.
    i_read = 1'b1; i_address = 32'h60;
    push_exp(1'b0, 1'b1, 32'h0000_0013);
    @(negedge clk);
    chk("fetch_latency", 32'(mem_read), 32'd0);
    tick();
    @(negedge clk);
    chk("fetch_mem_read", 32'(mem_read), 32'd1);
    chk("fetch_mem_addr", mem_address, 32'h60);
    chk("fetch_mem_be", 32'(mem_byte_enable), 32'hF);
    tick(); tick();
    mem_rdata = 32'h0000_0013; mem_resp = 1'b1;
    @(negedge clk);
    chk("fetch_read_at_resp", 32'(mem_read), 32'd1);
    tick();
    mem_resp = 1'b0; i_read = 1'b0;
    @(negedge clk);
    chk("fetch_read_drop", 32'(mem_read), 32'd0);
    tick();

    // Lone store, with the address changed while busy.
    d_write = 1'b1; d_address = 32'h100; d_wdata = 32'hDEAD_BEEF; d_byte_enable = 4'b0011;
    push_exp(1'b1, 1'b0, 32'd0);
    tick();
    @(negedge clk);
    chk("store_mem_write", 32'(mem_write), 32'd1);
    chk("store_mem_read", 32'(mem_read), 32'd0);
    chk("store_mem_addr", mem_address, 32'h100);
    chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("store_mem_be", 32'(mem_byte_enable), 32'h3);
    tick();
    d_address = 32'h200; d_wdata = 32'h0BAD_F00D; d_byte_enable = 4'b1111;
    @(negedge clk);
    chk("store_addr_hold", mem_address, 32'h100);
    chk("store_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
    chk("store_be_hold", 32'(mem_byte_enable), 32'h3);
    tick();
    mem_resp = 1'b1;
    @(negedge clk);
    chk("store_i_resp_quiet", 32'(i_resp), 32'd0);
    tick();
    mem_resp = 1'b0; d_write = 1'b0;
    @(negedge clk);
    chk("store_write_drop", 32'(mem_write), 32'd0);
    tick();

    // Stray mem_resp while idle.
    mem_resp = 1'b1;
    @(negedge clk);
    chk("stray_resp", {30'd0, i_resp, d_resp}, 32'd0);
    tick();
    mem_resp = 1'b0;
    tick();

    // Read and write both asserted: write wins for the whole transaction.
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h44; d_wdata = 32'h1234; d_byte_enable = 4'b1100;
    push_exp(1'b1, 1'b0, 32'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rw_mem_write", 32'(mem_write), 32'd1);
      chk("rw_mem_read", 32'(mem_read), 32'd0);
      chk("rw_mem_be", 32'(mem_byte_enable), 32'hC);
      tick();
    end
    mem_resp = 1'b1;
    @(negedge clk);
    chk("rw_mem_write_resp", 32'(mem_write), 32'd1);
    tick();
    mem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
    tick();

    // Reset mid-fetch abandons the access; held request is re-granted afterwards.
    i_read = 1'b1; i_address = 32'h80;
    tick();
    @(negedge clk);
    chk("rstmid_busy", 32'(mem_read), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_read_drop", 32'(mem_read), 32'd0);
    chk("rstmid_addr_clr", mem_address, 32'd0);
    chk("rstmid_no_resp", 32'(i_resp), 32'd0);
    tick();
    push_exp(1'b0, 1'b1, 32'hCAFE_0080);
    @(negedge clk);
    chk("rstmid_regrant", 32'(mem_read), 32'd1);
    chk("rstmid_regrant_addr", mem_address, 32'h80);
    tick();
    mem_rdata = 32'hCAFE_0080; mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; i_read = 1'b0;
    tick();

    // Conflict fairness: both held from reset, expect D, I, D, I ...
    rst = 1'b1;
    i_read = 1'b1; i_address = 32'h1000;
    d_read = 1'b1; d_address = 32'h2000;
    tick(); tick();
    rst = 1'b0;
    i0 = n_i_resp; d0 = n_d_resp;
    for (int k = 0; k < 20; k++) begin
      exp_side = (k % 2 == 0) ? 1'b1 : 1'b0;
      seen = 1'b0;
      for (int w = 0; w < 8 && !seen; w++) begin
        @(negedge clk);
        if (mem_read || mem_write) seen = 1'b1;
      end
      chk("fair_grant_seen", 32'(seen), 32'd1);
      if (!seen) break;
      chk("fair_grant_addr", mem_address, exp_side ? 32'h2000 : 32'h1000);
      push_exp(exp_side, 1'b1, 32'hAAAA_0000 + 32'(k));
      tick();
      mem_rdata = 32'hAAAA_0000 + 32'(k); mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
    end
    i_read = 1'b0; d_read = 1'b0;
    tick(); tick();
    chk("fair_i_count", 32'(n_i_resp - i0), 32'd10);
    chk("fair_d_count", 32'(n_d_resp - d0), 32'd10);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
